secuenciador_patrones: RTL and testbench
========================================

# secuenciador_patrones

Sequencing controller for the serial-to-parallel pattern datapath. It frames a qualified serial bit stream into N-bit words and runs an ordered-match state machine: pattern A, then B, then C, each within a programmable word timeout. It reports completed words, detections and timeouts, and keeps a saturating hit count. It sits between the serial front end and the host logic that programs the patterns and starts or stops a search.

## Interface
- N, 4: word width in bits, N ≥ 2.
- LOGN, 2: bit-counter width, 2^LOGN ≥ N.
- TMO_W, 8: width of the timeout field and the word timer.
- CNT_W, 8: width of the hit counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a search. Honoured only in IDLE.
- stop  in  1  abort the search and return to IDLE.
- entrada_serie  in  1  serial data bit.
- bit_valid  in  1  qualifies entrada_serie for the current cycle.
- patron_A / patron_B / patron_C  in  N each  patterns, sampled at evaluation time.
- timeout  in  TMO_W  number of non-matching words allowed between stages.
- busy  out  1  high when state ≠ IDLE.
- estado  out  2  state encoding: IDLE=0, WAIT_A=1, WAIT_B=2, WAIT_C=3.
- word_out  out  N  last completed word.
- word_valid  out  1  one-cycle pulse when word_out updates.
- detect  out  1  one-cycle pulse when the A→B→C sequence completes.
- fail  out  1  one-cycle pulse when a stage times out.
- hits  out  CNT_W  count of detections; saturates at all-ones.

## Operation
- Reset (rst_n low, asynchronous) sets state=IDLE and clears every output, the shift register, the bit counter and the word timer. hits is cleared only by reset.
- In IDLE, bits are ignored.
- start in IDLE moves to WAIT_A and clears the bit counter and the shift register.
- If start and stop are high together, stop wins.
- start while busy is ignored.
- stop in any non-IDLE state returns to IDLE at the next edge. It has priority over a word completing in the same cycle: no word_valid, detect or fail is produced.
- Framing, in non-IDLE states on each cycle with bit_valid=1:
  - Shift MSB-first: shift ← {shift[N-2:0], entrada_serie}.
  - Bit counter increments and wraps N-1 → 0.
  - Gaps in bit_valid hold all framing state.
- A word completes when bit_valid=1 and the counter is at N-1. The completed word is W = {shift[N-2:0], entrada_serie}, and it is evaluated in that same cycle.
- Evaluation of W by state:
  - WAIT_A: if W==A, go to WAIT_B and load timer ← timeout. Otherwise stay in WAIT_A.
  - WAIT_B:
    - W==B: go to WAIT_C and reload the timer.
    - Else W==A: stay in WAIT_B and reload the timer (restart the sequence).
    - Else timer==0: pulse fail and go to WAIT_A.
    - Else: decrement the timer.
  - WAIT_C:
    - W==C: pulse detect, hits += 1 (saturating), go to WAIT_A.
    - Else W==A: go to WAIT_B and reload the timer.
    - Else timer==0: pulse fail and go to WAIT_A.
    - Else: decrement the timer.
- Match priority when patterns coincide: the stage-advance match beats the A-restart match.
- timeout=0: the very next word must match.
- Patterns and timeout are combinational inputs at evaluation time and are not latched at start.

## Timing
- word_valid, word_out, detect and fail are registered. They appear in the cycle after the edge that captured the Nth valid bit, so latency is 1 clk from that bit's valid cycle.
- With continuous bit_valid, word_valid pulses every N cycles.
- detect and fail are mutually exclusive and each coincides with word_valid.
- busy and estado reflect the registered state.
- hits updates in the same cycle detect is high.
- An asynchronous reset asserted mid-word discards the partial word.
- A stop issued mid-word discards the partial word. The next start begins framing at bit 0.

## Test plan
Common setup unless noted: N=4, A=1010, B=1100, C=0011, timeout=2, continuous bit_valid.

- Reset, then start, then serial stream 1010 1100 0011 (MSB first) → word_valid ×3 with word_out 1010, 1100, 0011. detect pulses with the third word_valid, hits=1, estado returns to 1.
- Stream 1010 then 1111 ×3 → fail pulses with the fourth word_valid, estado=1, hits unchanged. With 1111 ×2 then 1100, there is no fail and estado=3.
- Stream 1010 1100 1010 1100 0011 → the A-restart from WAIT_C moves to WAIT_B, then detect pulses once, on the 5th word.
- Toggle bit_valid every other cycle while sending 1010 → word_valid arrives 1 cycle after the 4th valid bit, and word_out=1010.
- Assert stop in the same cycle as the 4th bit of a word that would complete the sequence → estado=0, with no word_valid, detect or fail.
- Preload hits=255 through repeated detections at CNT_W=8, then one more sequence → hits stays 255 and detect still pulses.
- Assert rst_n low mid-word → all outputs are 0 asynchronously.

Source files
------------

// File: rtl/secuenciador_patrones_if.sv
// Host-side bundle for secuenciador_patrones: search control, serial input, patterns and reports.
interface secuenciador_patrones_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned TMO_W = 8,
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic             stop;
  logic             entrada_serie;
  logic             bit_valid;
  logic [N-1:0]     patron_A;
  logic [N-1:0]     patron_B;
  logic [N-1:0]     patron_C;
  logic [TMO_W-1:0] timeout;
  logic             busy;
  logic [1:0]       estado;
  logic [N-1:0]     word_out;
  logic             word_valid;
  logic             detect;
  logic             fail;
  logic [CNT_W-1:0] hits;

  modport master (
    output start, stop, entrada_serie, bit_valid, patron_A, patron_B, patron_C, timeout,
    input  busy, estado, word_out, word_valid, detect, fail, hits
  );

  modport slave (
    input  start, stop, entrada_serie, bit_valid, patron_A, patron_B, patron_C, timeout,
    output busy, estado, word_out, word_valid, detect, fail, hits
  );
endinterface

// File: rtl/secuenciador_patrones.sv
// Frames a qualified MSB-first serial stream into N-bit words and tracks the ordered
// A -> B -> C pattern match with a per-stage word timeout and a saturating hit counter.
module secuenciador_patrones #(
  parameter int unsigned N     = 4,
  parameter int unsigned LOGN  = 2,
  parameter int unsigned TMO_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  secuenciador_patrones_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWaitA = 2'd1,
    StWaitB = 2'd2,
    StWaitC = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [N-2:0]     shift_q, shift_d;
  logic [LOGN-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [N-1:0]     word_out_q, word_out_d;
  logic             word_valid_q, word_valid_d;
  logic             detect_q, detect_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] hits_q, hits_d;

  logic [N-1:0] word;
  logic         word_done;
  logic         match_a, match_b, match_c, timer_zero;

  assign word       = {shift_q, bus.entrada_serie};
  assign word_done  = bus.bit_valid && (cnt_q == LOGN'(N - 1));
  assign match_a    = (word == bus.patron_A);
  assign match_b    = (word == bus.patron_B);
  assign match_c    = (word == bus.patron_C);
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    word_out_d   = word_out_q;
    word_valid_d = 1'b0;
    detect_d     = 1'b0;
    fail_d       = 1'b0;
    hits_d       = hits_q;

    if (state_q == StIdle) begin
      if (bus.start && !bus.stop) begin
        state_d = StWaitA;
        shift_d = '0;
        cnt_d   = '0;
      end
    end else if (bus.stop) begin
      // Abort wins over a word completing in this cycle; the partial word is dropped.
      state_d = StIdle;
      cnt_d   = '0;
    end else if (bus.bit_valid) begin
      shift_d = word[N-2:0];
      cnt_d   = word_done ? '0 : cnt_q + LOGN'(1);
      if (word_done) begin
        word_out_d   = word;
        word_valid_d = 1'b1;
        // Stage-advance matches are tested before the A-restart match.
        unique case (state_q)
          StWaitA: begin
            if (match_a) begin
              state_d = StWaitB;
              timer_d = bus.timeout;
            end
          end
          StWaitB: begin
            if (match_b) begin
              state_d = StWaitC;
              timer_d = bus.timeout;
            end else if (match_a) begin
              timer_d = bus.timeout;
            end else if (timer_zero) begin
              fail_d  = 1'b1;
              state_d = StWaitA;
            end else begin
              timer_d = timer_q - TMO_W'(1);
            end
          end
          StWaitC: begin
            if (match_c) begin
              detect_d = 1'b1;
              state_d  = StWaitA;
              if (hits_q != '1) hits_d = hits_q + CNT_W'(1);
            end else if (match_a) begin
              state_d = StWaitB;
              timer_d = bus.timeout;
            end else if (timer_zero) begin
              fail_d  = 1'b1;
              state_d = StWaitA;
            end else begin
              timer_d = timer_q - TMO_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      word_out_q   <= '0;
      word_valid_q <= 1'b0;
      detect_q     <= 1'b0;
      fail_q       <= 1'b0;
      hits_q       <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      detect_q     <= detect_d;
      fail_q       <= fail_d;
      hits_q       <= hits_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.estado     = state_q;
  assign bus.word_out   = word_out_q;
  assign bus.word_valid = word_valid_q;
  assign bus.detect     = detect_q;
  assign bus.fail       = fail_q;
  assign bus.hits       = hits_q;

endmodule

// File: tb/tb_secuenciador_patrones.sv
// Directed bench for secuenciador_patrones at N=4: framing, ordered match, timeout,
// stop priority, bit_valid gaps, hit saturation and asynchronous reset.
module tb_secuenciador_patrones;
  localparam int unsigned N     = 4;
  localparam int unsigned LOGN  = 2;
  localparam int unsigned TMO_W = 8;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  secuenciador_patrones_if #(.N(N), .TMO_W(TMO_W), .CNT_W(CNT_W)) bus ();

  secuenciador_patrones #(
    .N    (N),
    .LOGN (LOGN),
    .TMO_W(TMO_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one word MSB-first with continuous bit_valid; returns 1 ns after the last capture.
  task automatic send_word(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
      bus.entrada_serie = w[i];
      bus.bit_valid     = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_check(input string tag, input logic [N-1:0] w, input logic det,
                            input logic fl, input logic [1:0] est);
    send_word(w);
    check_eq({tag, ".wv"}, 32'(bus.word_valid), 32'd1);
    check_eq({tag, ".wo"}, 32'(bus.word_out), 32'(w));
    check_eq({tag, ".det"}, 32'(bus.detect), 32'(det));
    check_eq({tag, ".fail"}, 32'(bus.fail), 32'(fl));
    check_eq({tag, ".est"}, 32'(bus.estado), 32'(est));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.entrada_serie = 1'b0;
    bus.bit_valid     = 1'b0;
    bus.patron_A      = 4'b1010;
    bus.patron_B      = 4'b1100;
    bus.patron_C      = 4'b0011;
    bus.timeout       = 8'd2;

    tick();
    tick();
    check_eq("rst.busy", 32'(bus.busy), 32'd0);
    check_eq("rst.est", 32'(bus.estado), 32'd0);
    check_eq("rst.wv", 32'(bus.word_valid), 32'd0);
    check_eq("rst.hits", 32'(bus.hits), 32'd0);
    rst_n = 1'b1;
    tick();

    // start and stop together in IDLE: stop wins
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_eq("ss.est", 32'(bus.estado), 32'd0);

    pulse_start();
    check_eq("start.est", 32'(bus.estado), 32'd1);
    check_eq("start.busy", 32'(bus.busy), 32'd1);

    // Basic A B C
    send_check("abc.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("abc.b", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("abc.c", 4'b0011, 1'b1, 1'b0, 2'd1);
    check_eq("abc.hits", 32'(bus.hits), 32'd1);
    tick();
    check_eq("abc.wv_pulse", 32'(bus.word_valid), 32'd0);
    check_eq("abc.det_pulse", 32'(bus.detect), 32'd0);

    // Timeout in WAIT_B
    send_check("tmo.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("tmo.x1", 4'b1111, 1'b0, 1'b0, 2'd2);
    send_check("tmo.x2", 4'b1111, 1'b0, 1'b0, 2'd2);
    send_check("tmo.x3", 4'b1111, 1'b0, 1'b1, 2'd1);
    check_eq("tmo.hits", 32'(bus.hits), 32'd1);

    // Two misses still within budget, then B
    send_check("tin.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("tin.x1", 4'b1111, 1'b0, 1'b0, 2'd2);
    send_check("tin.x2", 4'b1111, 1'b0, 1'b0, 2'd2);
    send_check("tin.b", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("tin.c", 4'b0011, 1'b1, 1'b0, 2'd1);
    check_eq("tin.hits", 32'(bus.hits), 32'd2);

    // A-restart from WAIT_C
    send_check("rs.a1", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("rs.b1", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("rs.a2", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("rs.b2", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("rs.c", 4'b0011, 1'b1, 1'b0, 2'd1);
    check_eq("rs.hits", 32'(bus.hits), 32'd3);

    // timeout = 0: the very next word must match
    bus.timeout = 8'd0;
    send_check("t0.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("t0.x", 4'b0110, 1'b0, 1'b1, 2'd1);
    bus.timeout = 8'd2;

    // bit_valid toggling every other cycle
    for (int i = N - 1; i >= 0; i--) begin
      bus.entrada_serie = i[0] ? 1'b1 : 1'b0;  // 1010
      bus.bit_valid     = 1'b1;
      tick();
      if (i != 0) begin
        check_eq("gap.wv_early", 32'(bus.word_valid), 32'd0);
        bus.bit_valid     = 1'b0;
        bus.entrada_serie = ~bus.entrada_serie;
        tick();
      end
    end
    bus.bit_valid = 1'b0;
    check_eq("gap.wv", 32'(bus.word_valid), 32'd1);
    check_eq("gap.wo", 32'(bus.word_out), 32'hA);
    check_eq("gap.est", 32'(bus.estado), 32'd2);

    // Start while busy is ignored
    pulse_start();
    check_eq("sbusy.est", 32'(bus.estado), 32'd2);
    send_check("stp.b", 4'b1100, 1'b0, 1'b0, 2'd3);

    // stop on the 4th bit of a completing C word
    for (int i = N - 1; i >= 0; i--) begin
      bus.entrada_serie = (i < 2) ? 1'b1 : 1'b0;
      bus.bit_valid     = 1'b1;
      bus.stop          = (i == 0);
      tick();
    end
    bus.bit_valid = 1'b0;
    bus.stop      = 1'b0;
    check_eq("stp.est", 32'(bus.estado), 32'd0);
    check_eq("stp.wv", 32'(bus.word_valid), 32'd0);
    check_eq("stp.det", 32'(bus.detect), 32'd0);
    check_eq("stp.fail", 32'(bus.fail), 32'd0);
    check_eq("stp.hits", 32'(bus.hits), 32'd3);

    // Partial word then stop; restart must frame from bit 0
    pulse_start();
    send_word(4'b1100);  // not A: consumes framing
    bus.entrada_serie = 1'b1;
    bus.bit_valid     = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bus.stop      = 1'b1;
    tick();
    bus.stop = 1'b0;
    pulse_start();
    send_check("rfr.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("rfr.b", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("rfr.c", 4'b0011, 1'b1, 1'b0, 2'd1);
    check_eq("rfr.hits", 32'(bus.hits), 32'd4);

    // Saturation: 251 more detections bring hits to 255
    for (int k = 0; k < 251; k++) begin
      send_word(4'b1010);
      send_word(4'b1100);
      send_word(4'b0011);
    end
    check_eq("sat.hits255", 32'(bus.hits), 32'd255);
    send_check("sat.a", 4'b1010, 1'b0, 1'b0, 2'd2);
    send_check("sat.b", 4'b1100, 1'b0, 1'b0, 2'd3);
    send_check("sat.c", 4'b0011, 1'b1, 1'b0, 2'd1);
    check_eq("sat.hits", 32'(bus.hits), 32'd255);

    // Asynchronous reset mid-word
    bus.entrada_serie = 1'b1;
    bus.bit_valid     = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.busy", 32'(bus.busy), 32'd0);
    check_eq("arst.est", 32'(bus.estado), 32'd0);
    check_eq("arst.wo", 32'(bus.word_out), 32'd0);
    check_eq("arst.hits", 32'(bus.hits), 32'd0);
    check_eq("arst.pulses", 32'({bus.word_valid, bus.detect, bus.fail}), 32'd0);
    bus.bit_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
